// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared widths and ALU/main-op encodings for the RV64 core
package core_pkg;

    localparam int XLEN   = 64;
    localparam int REG_AW = 5;

    localparam logic [3:0] ALU_AND     = 4'b0000;
    localparam logic [3:0] ALU_OR      = 4'b0001;
    localparam logic [3:0] ALU_ADD     = 4'b0010;
    localparam logic [3:0] ALU_SUB     = 4'b0011;
    localparam logic [3:0] ALU_XOR     = 4'b0100;
    localparam logic [3:0] ALU_SLL     = 4'b0101;
    localparam logic [3:0] ALU_SRL     = 4'b0110;
    localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

    localparam logic [1:0] MAIN_ADD   = 2'b00;
    localparam logic [1:0] MAIN_SUB   = 2'b01;
    localparam logic [1:0] MAIN_RTYPE = 2'b10;
    localparam logic [1:0] MAIN_ITYPE = 2'b11;

endpackage

// File: rtl/alu_control.sv
// rtl/alu_control.sv - combinational decode of main op, funct3 and bit 30 into the 4-bit ALU op
module alu_control
    import core_pkg::*;
#(
    parameter logic [3:0] ILLEGAL_OP = ALU_ILLEGAL
) (
    input  logic [1:0] i_alu_op_main,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_5,
    output logic [3:0] o_alu_op,
    output logic       o_illegal
);

    logic w_is_rtype;

    assign w_is_rtype = (i_alu_op_main == MAIN_RTYPE);

    always_comb begin
        o_alu_op  = ILLEGAL_OP;
        o_illegal = 1'b1;
        case (i_alu_op_main)
            MAIN_ADD: begin
                o_alu_op  = ALU_ADD;
                o_illegal = 1'b0;
            end
            MAIN_SUB: begin
                o_alu_op  = ALU_SUB;
                o_illegal = 1'b0;
            end
            default: begin
                // R-type and I-type share the funct3 table; only R-type uses bit 30 to pick sub
                case (i_funct3)
                    3'b000: begin
                        o_alu_op  = (w_is_rtype && i_funct7_5) ? ALU_SUB : ALU_ADD;
                        o_illegal = 1'b0;
                    end
                    3'b111: begin
                        o_alu_op  = ALU_AND;
                        o_illegal = 1'b0;
                    end
                    3'b110: begin
                        o_alu_op  = ALU_OR;
                        o_illegal = 1'b0;
                    end
                    3'b100: begin
                        o_alu_op  = ALU_XOR;
                        o_illegal = 1'b0;
                    end
                    3'b001: begin
                        o_alu_op  = ALU_SLL;
                        o_illegal = 1'b0;
                    end
                    3'b101: begin
                        if (!i_funct7_5) begin
                            o_alu_op  = ALU_SRL;
                            o_illegal = 1'b0;
                        end
                    end
                    default: begin
                        o_alu_op  = ILLEGAL_OP;
                        o_illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding
module id_ex_stage
    import core_pkg::*;
#(
    parameter int         XLEN       = core_pkg::XLEN,
    parameter int         REG_AW     = core_pkg::REG_AW,
    parameter logic [3:0] ILLEGAL_OP = ALU_ILLEGAL
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_alu_src,
    input  logic [1:0]        id_alu_op_main,
    input  logic [2:0]        id_funct3,
    input  logic              id_funct7_5,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              id_branch,
    input  logic              exmem_reg_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [XLEN-1:0]   exmem_result,
    input  logic              memwb_reg_write,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [XLEN-1:0]   memwb_data,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_a,
    output logic [XLEN-1:0]   ex_b,
    output logic [3:0]        ex_alu_op,
    output logic [XLEN-1:0]   ex_store_data,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_imm,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              ex_branch,
    output logic              ex_illegal
);

    logic              r_valid;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_rs1_data;
    logic [XLEN-1:0]   r_rs2_data;
    logic [XLEN-1:0]   r_imm;
    logic [REG_AW-1:0] r_rs1;
    logic [REG_AW-1:0] r_rs2;
    logic [REG_AW-1:0] r_rd;
    logic              r_alu_src;
    logic [1:0]        r_alu_op_main;
    logic [2:0]        r_funct3;
    logic              r_funct7_5;
    logic              r_reg_write;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_mem_to_reg;
    logic              r_branch;

    logic [XLEN-1:0]   w_fwd_rs1;
    logic [XLEN-1:0]   w_fwd_rs2;
    logic              w_illegal;

    // EX/MEM is younger than MEM/WB, so it wins; x0 is hard-wired and never forwards
    always_comb begin
        w_fwd_rs1 = r_rs1_data;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == r_rs1))
            w_fwd_rs1 = exmem_result;
        else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == r_rs1))
            w_fwd_rs1 = memwb_data;
    end

    always_comb begin
        w_fwd_rs2 = r_rs2_data;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == r_rs2))
            w_fwd_rs2 = exmem_result;
        else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == r_rs2))
            w_fwd_rs2 = memwb_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid       <= 1'b0;
            r_pc          <= '0;
            r_rs1_data    <= '0;
            r_rs2_data    <= '0;
            r_imm         <= '0;
            r_rs1         <= '0;
            r_rs2         <= '0;
            r_rd          <= '0;
            r_alu_src     <= 1'b0;
            r_alu_op_main <= 2'b00;
            r_funct3      <= 3'b000;
            r_funct7_5    <= 1'b0;
            r_reg_write   <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_to_reg  <= 1'b0;
            r_branch      <= 1'b0;
        end else if (flush) begin
            r_valid      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_branch     <= 1'b0;
        end else if (stall) begin
            // Capture producers that retire while we wait, otherwise their value is lost
            if (r_valid) begin
                r_rs1_data <= w_fwd_rs1;
                r_rs2_data <= w_fwd_rs2;
            end
        end else begin
            r_valid       <= id_valid;
            r_pc          <= id_pc;
            r_rs1_data    <= id_rs1_data;
            r_rs2_data    <= id_rs2_data;
            r_imm         <= id_imm;
            r_rs1         <= id_rs1;
            r_rs2         <= id_rs2;
            r_rd          <= id_rd;
            r_alu_src     <= id_alu_src;
            r_alu_op_main <= id_alu_op_main;
            r_funct3      <= id_funct3;
            r_funct7_5    <= id_funct7_5;
            r_reg_write   <= id_reg_write;
            r_mem_read    <= id_mem_read;
            r_mem_write   <= id_mem_write;
            r_mem_to_reg  <= id_mem_to_reg;
            r_branch      <= id_branch;
        end
    end

    alu_control #(
        .ILLEGAL_OP (ILLEGAL_OP)
    ) u_alu_control (
        .i_alu_op_main (r_alu_op_main),
        .i_funct3      (r_funct3),
        .i_funct7_5    (r_funct7_5),
        .o_alu_op      (ex_alu_op),
        .o_illegal     (w_illegal)
    );

    assign ex_valid      = r_valid;
    assign ex_a          = w_fwd_rs1;
    assign ex_b          = r_alu_src ? r_imm : w_fwd_rs2;
    assign ex_store_data = w_fwd_rs2;
    assign ex_pc         = r_pc;
    assign ex_imm        = r_imm;
    assign ex_rd         = r_rd;
    assign ex_reg_write  = r_valid & r_reg_write;
    assign ex_mem_read   = r_valid & r_mem_read;
    assign ex_mem_write  = r_valid & r_mem_write;
    assign ex_mem_to_reg = r_valid & r_mem_to_reg;
    assign ex_branch     = r_valid & r_branch;
    assign ex_illegal    = r_valid & w_illegal;

endmodule
